// File: rtl/correlation_bin_mapper.sv
// correlation_bin_mapper
//   Turns start/stop detector events into histogram bin increments. A rising
//   edge on data_arrived qualifies one event; events whose channel pair
//   matches the selected (ch_a, ch_b) pair are mapped to a bin around CENTER,
//   buffered in a small FIFO, and replayed as an addr + mem_add strobe that
//   lasts HOLD_CYC cycles followed by one idle cycle.
//
//   Optional feature macro: CBM_STATS_EN -- when defined, drop_cnt/range_cnt
//   are live saturating counters; otherwise both are tied to zero.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   start_ch     : channel code of the start event
//   end_ch       : channel code of the stop event
//   interval     : coarse delay between start and stop
//   ch_a, ch_b   : selected correlation channel pair
//   data_arrived : level qualifying the event inputs (rising edge = event)
//   addr         : histogram bin address
//   mem_add      : histogram increment strobe
//   busy         : FIFO non-empty or output FSM active
//   drop_cnt     : events lost to pair mismatch or FIFO overflow
//   range_cnt    : events whose bin fell outside the address space
module correlation_bin_mapper #(
  parameter int CH_W       = 2,
  parameter int INT_W      = 7,
  parameter int ADDR_W     = 8,
  parameter int CENTER     = 128,
  parameter int HOLD_CYC   = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH_W-1:0]   start_ch,
  input  logic [CH_W-1:0]   end_ch,
  input  logic [INT_W-1:0]  interval,
  input  logic [CH_W-1:0]   ch_a,
  input  logic [CH_W-1:0]   ch_b,
  input  logic              data_arrived,
  output logic [ADDR_W-1:0] addr,
  output logic              mem_add,
  output logic              busy,
  output logic [15:0]       drop_cnt,
  output logic [15:0]       range_cnt
);

  localparam int SW = ADDR_W + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  HOLD_LOAD = 4'(HOLD_CYC - 1);
  localparam logic [PW:0] FULL_CNT  = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  // ---------------------------------------------------------------- detect
  logic da_q;
  logic ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) da_q <= 1'b0;
    else     da_q <= data_arrived;
  end

  assign ev = data_arrived & ~da_q;

  // -------------------------------------------------------------- classify
  logic fwd, rev, pair_ok, in_range;
  logic signed [SW-1:0] center_s, iv_s, bin;

  assign center_s = SW'(CENTER);
  assign iv_s     = SW'(interval);
  assign fwd      = (start_ch == ch_a) && (end_ch == ch_b);
  assign rev      = (start_ch == ch_b) && (end_ch == ch_a);
  assign pair_ok  = fwd | rev;

  always_comb begin
    bin = center_s;
    if (interval != '0) begin
      if (fwd)      bin = center_s + iv_s;
      else if (rev) bin = center_s - iv_s;
    end
  end

  // With interval no wider than the address, every out-of-range result
  // (negative or overflowing 2^ADDR_W-1) lands with the sign bit set.
  assign in_range = ~bin[SW-1];

  // ------------------------------------------------------------------ FIFO
  logic [ADDR_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic              full, empty, push, pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = ev & pair_ok & in_range & (~full | pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bin[ADDR_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ------------------------------------------------------------ output FSM
  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic [ADDR_W-1:0] addr_int, addr_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_int <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      addr_int <= addr_n;
    end
  end

  // GAP falls straight through IDLE when work is pending, so back-to-back
  // strobes are separated by exactly the single GAP cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr_int;
    pop     = 1'b0;
    case (state)
      IDLE, GAP: begin
        if (!empty) begin
          pop     = 1'b1;
          addr_n  = mem[rd_ptr];
          cnt_n   = HOLD_LOAD;
          state_n = HOLD;
        end else begin
          state_n = IDLE;
        end
      end
      HOLD: begin
        if (cnt == '0) state_n = GAP;
        else           cnt_n   = cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Output stage: addr and mem_add are re-registered together, placing the
  // strobe two edges after the detecting edge and keeping addr stable for
  // the whole strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_add <= 1'b0;
      addr    <= '0;
    end else begin
      mem_add <= (state == HOLD);
      addr    <= addr_int;
    end
  end

  assign busy = ~empty | (state != IDLE);

  // ------------------------------------------------------------ statistics
`ifdef CBM_STATS_EN
  logic drop_inc, range_inc;

  assign drop_inc  = ev & (~pair_ok | (in_range & full & ~pop));
  assign range_inc = ev & pair_ok & ~in_range;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt  <= '0;
      range_cnt <= '0;
    end else begin
      if (drop_inc && drop_cnt != '1)   drop_cnt  <= drop_cnt + 1'b1;
      if (range_inc && range_cnt != '1) range_cnt <= range_cnt + 1'b1;
    end
  end
`else
  assign drop_cnt  = '0;
  assign range_cnt = '0;
`endif

endmodule

// File: tb/tb_correlation_bin_mapper.sv
// Scoreboard bench for correlation_bin_mapper. A queue-level reference model
// (pending-event queue plus a "next free edge" for the output engine) turns
// each stimulus edge into expected strobes; a negedge monitor pops and checks
// address, start edge, strobe length and address stability.
module tb_correlation_bin_mapper;

  localparam int HOLD_CYC = 6;
  localparam int DEPTH    = 4;
  localparam int C1       = 128;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] start_ch = '0, end_ch = '0, ch_a = '0, ch_b = '0;
  logic [6:0] interval = '0;
  logic       data_arrived = 1'b0;
  logic [7:0] addr;
  logic       mem_add, busy;
  logic [15:0] drop_cnt, range_cnt;

  logic [1:0] s2 = '0, e2 = '0, a2 = 2'd1, b2 = 2'd2;
  logic [6:0] iv2 = '0;
  logic       da2 = 1'b0;
  logic [7:0] addr2;
  logic       mem_add2, busy2;
  logic [15:0] drop2, range2;

  correlation_bin_mapper #(.CH_W(2), .INT_W(7), .ADDR_W(8), .CENTER(C1),
                           .HOLD_CYC(HOLD_CYC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start_ch(start_ch), .end_ch(end_ch),
    .interval(interval), .ch_a(ch_a), .ch_b(ch_b), .data_arrived(data_arrived),
    .addr(addr), .mem_add(mem_add), .busy(busy),
    .drop_cnt(drop_cnt), .range_cnt(range_cnt));

  correlation_bin_mapper #(.CH_W(2), .INT_W(7), .ADDR_W(8), .CENTER(200),
                           .HOLD_CYC(HOLD_CYC), .FIFO_DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst(rst), .start_ch(s2), .end_ch(e2),
    .interval(iv2), .ch_a(a2), .ch_b(b2), .data_arrived(da2),
    .addr(addr2), .mem_add(mem_add2), .busy(busy2),
    .drop_cnt(drop2), .range_cnt(range2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ------------------------------------------------------ reference model
  typedef struct {int a; int rise;} exp_t;
  exp_t expq[$];
  int   mq[$];
  int   free_at = 0;
  bit   m_prev  = 1'b0;
  int   m_drop  = 0;
  int   m_range = 0;

  function automatic int exp_stat(int v);
`ifdef CBM_STATS_EN
    return (v > 65535) ? 65535 : v;
`else
    return 0 * v;
`endif
  endfunction

  // kind: 0 = binned, 1 = pair mismatch, 2 = out of range
  function automatic int classify(int s, int e, int iv, int a, int b,
                                  int center, output int kind);
    int bin;
    kind = 0;
    bin  = center;
    if (s == a && e == b)      bin = center + iv;
    else if (s == b && e == a) bin = center - iv;
    else                       kind = 1;
    if (kind == 0 && (bin < 0 || bin > 255)) kind = 2;
    return bin;
  endfunction

  task automatic model_step(input int k);
    int   bin, kind, v;
    exp_t x;
    if (mq.size() > 0 && k >= free_at) begin
      v = mq.pop_front();
      x.a = v;
      x.rise = k + 1;
      expq.push_back(x);
      free_at = k + HOLD_CYC + 1;
    end
    if (data_arrived && !m_prev) begin
      bin = classify(int'(start_ch), int'(end_ch), int'(interval),
                     int'(ch_a), int'(ch_b), C1, kind);
      case (kind)
        0: if (mq.size() < DEPTH) mq.push_back(bin); else m_drop++;
        1: m_drop++;
        default: m_range++;
      endcase
    end
    m_prev = data_arrived;
  endtask

  task automatic model_reset();
    mq.delete();
    expq.delete();
    free_at = 0;
    m_prev  = 1'b0;
  endtask

  // -------------------------------------------------------------- monitor
  bit ma_prev = 1'b0, in_strobe = 1'b0, stable = 1'b0;
  int hi_len = 0, cur_addr = 0, n_rise = 0;

  always @(negedge clk) begin
    exp_t x;
    if (rst) begin
      ma_prev   = 1'b0;
      in_strobe = 1'b0;
    end else begin
      if (mem_add && !ma_prev) begin
        n_rise++;
        if (expq.size() == 0) begin
          check("pending_expected", 0, 1);
        end else begin
          x = expq.pop_front();
          check("strobe_addr", int'(addr), x.a);
          check("strobe_edge", cyc, x.rise);
        end
        in_strobe = 1'b1;
        hi_len    = 1;
        cur_addr  = int'(addr);
        stable    = 1'b1;
      end else if (mem_add && in_strobe) begin
        hi_len++;
        if (int'(addr) != cur_addr) stable = 1'b0;
      end else if (!mem_add && ma_prev && in_strobe) begin
        check("hold_len", hi_len, HOLD_CYC);
        check("addr_stable", int'(stable), 1);
        in_strobe = 1'b0;
      end
      ma_prev = mem_add;
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic step(input bit r, input bit d, input int s, input int e,
                      input int iv);
    @(negedge clk);
    rst          = r;
    data_arrived = d;
    start_ch     = 2'(s);
    end_ch       = 2'(e);
    interval     = 7'(iv);
    if (!r) model_step(cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic pulse_expect(input int s, input int e, input int iv,
                              input int exp_addr);
    step(1'b0, 1'b1, s, e, iv);
    step(1'b0, 1'b0, s, e, iv);
    check("lat_e0_low", int'(mem_add), 0);
    step(1'b0, 1'b0, s, e, iv);
    check("lat_e1_low", int'(mem_add), 0);
    step(1'b0, 1'b0, s, e, iv);
    check("lat_e2_high", int'(mem_add), 1);
    check("lat_e2_addr", int'(addr), exp_addr);
    idle(7);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      step(1'b0, 1'b0, 0, 0, 0);
      if (expq.size() == 0 && !mem_add && !busy) done = 1'b1;
    end
    if (!done) check("drain_timeout", 0, 1);
    idle(2);
  endtask

  initial begin
    int r0, d0, hi2, sel, s, e, iv;

    repeat (3) @(negedge clk);
    check("rst_addr", int'(addr), 0);
    check("rst_mem_add", int'(mem_add), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_drop", int'(drop_cnt), 0);
    check("rst_range", int'(range_cnt), 0);
    check("rst_addr2", int'(addr2), 0);
    step(1'b0, 1'b0, 0, 0, 0);
    idle(2);

    // zero lag, both orientations, +/- lag
    ch_a = 2'd0;
    ch_b = 2'd3;
    pulse_expect(0, 3, 0, 128);
    pulse_expect(3, 0, 0, 128);
    pulse_expect(0, 3, 5, 133);
    pulse_expect(3, 0, 5, 123);
    pulse_expect(0, 3, 127, 255);
    pulse_expect(3, 0, 127, 1);

    // mismatched pair -> no strobe
    r0 = n_rise;
    step(1'b0, 1'b1, 1, 2, 3);
    idle(12);
    check("mismatch_no_strobe", n_rise - r0, 0);
    check("mismatch_drop", int'(drop_cnt), exp_stat(m_drop));

    // burst: rising edges every other cycle overflow the FIFO
    r0 = n_rise;
    d0 = m_drop;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, 0, 3, 10 + i);
      step(1'b0, 1'b0, 0, 3, 0);
    end
    drain();
    check("burst_model_drops", m_drop - d0, 1);
    check("burst_drop", int'(drop_cnt), exp_stat(m_drop));
    check("burst_strobes", n_rise - r0, 6);

    // CENTER=200 instance: +100 out of range, -100 -> 100
    step(1'b0, 1'b0, 0, 0, 0);
    da2 = 1'b1; s2 = 2'd1; e2 = 2'd2; iv2 = 7'd100;
    step(1'b0, 1'b0, 0, 0, 0);
    da2 = 1'b0;
    hi2 = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 0, 0, 0);
      if (mem_add2 || busy2) hi2++;
    end
    check("range_no_strobe", hi2, 0);
    check("range_cnt", int'(range2), exp_stat(1));
    da2 = 1'b1; s2 = 2'd2; e2 = 2'd1; iv2 = 7'd100;
    step(1'b0, 1'b0, 0, 0, 0);
    da2 = 1'b0;
    check("neg100_e0", int'(mem_add2), 0);
    step(1'b0, 1'b0, 0, 0, 0);
    check("neg100_e1", int'(mem_add2), 0);
    step(1'b0, 1'b0, 0, 0, 0);
    check("neg100_strobe", int'(mem_add2), 1);
    check("neg100_addr", int'(addr2), 100);
    idle(8);

    // level held high for 20 cycles -> one event
    r0 = n_rise;
    repeat (20) step(1'b0, 1'b1, 3, 0, 2);
    step(1'b0, 1'b0, 0, 0, 0);
    drain();
    check("held_high_one", n_rise - r0, 1);

    // reset during third HOLD cycle
    step(1'b0, 1'b1, 0, 3, 9);
    repeat (5) step(1'b0, 1'b0, 0, 3, 9);
    check("hold3_high", int'(mem_add), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_hold_mem_add", int'(mem_add), 0);
    check("rst_hold_addr", int'(addr), 0);
    check("rst_hold_busy", int'(busy), 0);
    model_reset();
    step(1'b1, 1'b0, 0, 0, 0);
    step(1'b1, 1'b0, 0, 0, 0);
    step(1'b0, 1'b0, 0, 0, 0);
    r0 = n_rise;
    idle(20);
    check("rst_no_restrobe", n_rise - r0, 0);

    // data_arrived high across reset release counts as a rising edge
    step(1'b1, 1'b1, 0, 3, 4);
    model_reset();
    r0 = n_rise;
    step(1'b0, 1'b1, 0, 3, 4);
    step(1'b0, 1'b0, 0, 0, 0);
    drain();
    check("release_edge_strobe", n_rise - r0, 1);

    // randomized traffic
    for (int ph = 0; ph < 4; ph++) begin
      ch_a = 2'($urandom_range(0, 3));
      ch_b = 2'($urandom_range(0, 3));
      for (int i = 0; i < 100; i++) begin
        sel = $urandom_range(0, 3);
        iv  = $urandom_range(0, 127);
        case (sel)
          0:       begin s = int'(ch_a); e = int'(ch_b); end
          1:       begin s = int'(ch_b); e = int'(ch_a); end
          2:       begin s = $urandom_range(0, 3); e = $urandom_range(0, 3); end
          default: begin s = int'(ch_a); e = int'(ch_b); iv = 0; end
        endcase
        step(1'b0, ($urandom_range(0, 2) == 0), s, e, iv);
      end
      drain();
    end

    check("final_queue_empty", expq.size(), 0);
    check("final_drop", int'(drop_cnt), exp_stat(m_drop));
    check("final_range", int'(range_cnt), exp_stat(m_range));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
